// File: rtl/elevator_pkg.sv
// Shared types and default timing for the elevator call scheduler.
package elevator_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_t;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

    localparam int FLOOR_W        = 3;
    localparam int DEF_NFLOORS    = 5;
    localparam int DEF_TRAVEL_CYC = 4;
    localparam int DEF_DOOR_CYC   = 3;
endpackage

// File: rtl/elevator_call_latch.sv
// Pending-call register: latches call pulses, clears serviced floors and
// ignores calls that are masked off (the open-door floor).
module elevator_call_latch
    import elevator_pkg::*;
#(
    parameter int NFLOORS = DEF_NFLOORS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NFLOORS-1:0] req,
    input  logic [NFLOORS-1:0] clr,
    input  logic [NFLOORS-1:0] suppress,
    output logic [NFLOORS-1:0] pending
);
    logic [NFLOORS-1:0] pending_q;
    logic [NFLOORS-1:0] pending_d;

    always_comb begin
        pending_d = (pending_q | (req & ~suppress)) & ~clr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;
endmodule

// File: rtl/elevator_call_scheduler.sv
// SCAN call scheduler: picks the next stop from latched calls and sequences
// the car through travel and door-dwell phases with cycle counters.
module elevator_call_scheduler
    import elevator_pkg::*;
#(
    parameter int NFLOORS    = DEF_NFLOORS,
    parameter int TRAVEL_CYC = DEF_TRAVEL_CYC,
    parameter int DOOR_CYC   = DEF_DOOR_CYC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NFLOORS-1:0] req,
    output logic [FLOOR_W-1:0] floor,
    output logic               dir,
    output logic               moving,
    output logic               door_open,
    output logic [NFLOORS-1:0] pending
);
    localparam int TCNT_W = (TRAVEL_CYC > 1) ? $clog2(TRAVEL_CYC) : 1;
    localparam int DCNT_W = (DOOR_CYC > 1) ? $clog2(DOOR_CYC) : 1;
    localparam logic [TCNT_W-1:0]  TRAVEL_LAST = TCNT_W'(TRAVEL_CYC - 1);
    localparam logic [DCNT_W-1:0]  DOOR_LAST   = DCNT_W'(DOOR_CYC - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NFLOORS - 1);

    state_t              state_q, state_d;
    dir_t                dir_q, dir_d;
    logic [FLOOR_W-1:0]  floor_q, floor_d;
    logic [TCNT_W-1:0]   travel_cnt_q, travel_cnt_d;
    logic [DCNT_W-1:0]   door_cnt_q, door_cnt_d;
    logic                moving_q, moving_d;
    logic                door_open_q, door_open_d;

    logic [NFLOORS-1:0]  pending_q;
    logic [NFLOORS-1:0]  clr;
    logic [NFLOORS-1:0]  suppress;
    logic [NFLOORS-1:0]  floor_onehot;
    logic [NFLOORS-1:0]  step_onehot;
    logic [NFLOORS-1:0]  above_mask;
    logic [NFLOORS-1:0]  below_mask;
    logic [FLOOR_W-1:0]  step_floor;
    logic                ahead;
    logic                behind;
    logic                do_decide;

    genvar gi;
    generate
        for (gi = 0; gi < NFLOORS; gi++) begin : g_masks
            assign floor_onehot[gi] = (floor_q == FLOOR_W'(gi));
            assign step_onehot[gi]  = (step_floor == FLOOR_W'(gi));
            assign above_mask[gi]   = (FLOOR_W'(gi) > floor_q);
            assign below_mask[gi]   = (FLOOR_W'(gi) < floor_q);
        end
    endgenerate

    // A call for the floor whose door is open only restarts the dwell.
    assign suppress = (state_q == DOOR) ? floor_onehot : '0;

    elevator_call_latch #(
        .NFLOORS (NFLOORS)
    ) u_call_latch (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .clr      (clr),
        .suppress (suppress),
        .pending  (pending_q)
    );

    always_comb begin
        step_floor = floor_q;
        if (dir_q == UP && floor_q != TOP_FLOOR) begin
            step_floor = floor_q + 1'b1;
        end else if (dir_q == DOWN && floor_q != '0) begin
            step_floor = floor_q - 1'b1;
        end
    end

    assign ahead  = (dir_q == UP) ? |(pending_q & above_mask) : |(pending_q & below_mask);
    assign behind = (dir_q == UP) ? |(pending_q & below_mask) : |(pending_q & above_mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            dir_q        <= UP;
            floor_q      <= '0;
            travel_cnt_q <= '0;
            door_cnt_q   <= '0;
            moving_q     <= 1'b0;
            door_open_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            floor_q      <= floor_d;
            travel_cnt_q <= travel_cnt_d;
            door_cnt_q   <= door_cnt_d;
            moving_q     <= moving_d;
            door_open_q  <= door_open_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        floor_d      = floor_q;
        travel_cnt_d = travel_cnt_q;
        door_cnt_d   = door_cnt_q;
        clr          = '0;
        do_decide    = 1'b0;

        case (state_q)
            IDLE: begin
                do_decide = 1'b1;
            end
            MOVE: begin
                if (travel_cnt_q == TRAVEL_LAST) begin
                    travel_cnt_d = '0;
                    floor_d      = step_floor;
                    if (|(pending_q & step_onehot)) begin
                        state_d    = DOOR;
                        door_cnt_d = '0;
                        clr        = step_onehot;
                    end
                end else begin
                    travel_cnt_d = travel_cnt_q + 1'b1;
                end
            end
            DOOR: begin
                if (|(req & floor_onehot)) begin
                    door_cnt_d = '0;
                end else if (door_cnt_q == DOOR_LAST) begin
                    do_decide = 1'b1;
                end else begin
                    door_cnt_d = door_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // SCAN decision: serve here, else keep going, else reverse, else rest.
        if (do_decide) begin
            travel_cnt_d = '0;
            door_cnt_d   = '0;
            if (|(pending_q & floor_onehot)) begin
                state_d = DOOR;
                clr     = floor_onehot;
            end else if (ahead) begin
                state_d = MOVE;
            end else if (behind) begin
                state_d = MOVE;
                dir_d   = (dir_q == UP) ? DOWN : UP;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_comb begin
        moving_d    = (state_d == MOVE);
        door_open_d = (state_d == DOOR);
    end

    assign floor     = floor_q;
    assign dir       = dir_q;
    assign moving    = moving_q;
    assign door_open = door_open_q;
    assign pending   = pending_q;
endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Bench for elevator_call_scheduler: per-scenario vector tables feed a
// scoreboard of expected snapshots, plus a hand-written timing sequence.
module tb_elevator_call_scheduler;
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] req;
    logic [2:0] floor;
    logic       dir;
    logic       moving;
    logic       door_open;
    logic [4:0] pending;

    elevator_call_scheduler #(
        .NFLOORS    (5),
        .TRAVEL_CYC (4),
        .DOOR_CYC   (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .floor     (floor),
        .dir       (dir),
        .moving    (moving),
        .door_open (door_open),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         edge_i;
        logic       rst;
        logic [4:0] req;
        logic [2:0] floor;
        logic       dir;
        logic       moving;
        logic       door;
        logic [4:0] pending;
    } vec_t;

    typedef struct {
        int          edge_i;
        logic [10:0] v;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    int   n_edges;
    int   open_edge;
    int   close_edge;
    bit   overlap;

    function automatic void row(input int e, input logic r, input logic [4:0] q,
                                input int f, input logic d, input logic m,
                                input logic o, input logic [4:0] p);
        vec_t v;
        v.edge_i  = e;
        v.rst     = r;
        v.req     = q;
        v.floor   = 3'(f);
        v.dir     = d;
        v.moving  = m;
        v.door    = o;
        v.pending = p;
        tbl.push_back(v);
    endfunction

    task automatic check_snap(input string name, input int e, input logic [10:0] expv);
        logic [10:0] act;
        act = {floor, dir, moving, door_open, pending};
        checks++;
        if (act === expv) begin
            passed++;
            $display("ok   %s E%0d f=%0d d=%0d m=%0d o=%0d p=%b", name, e,
                     act[10:8], act[7], act[6], act[5], act[4:0]);
        end else begin
            $display("FAIL %s E%0d got f=%0d d=%0d m=%0d o=%0d p=%b expected f=%0d d=%0d m=%0d o=%0d p=%b",
                     name, e, act[10:8], act[7], act[6], act[5], act[4:0],
                     expv[10:8], expv[7], expv[6], expv[5], expv[4:0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int expv);
        checks++;
        if (act == expv) begin
            passed++;
            $display("ok   %s = %0d", name, act);
        end else begin
            $display("FAIL %s got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        req = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_snap({name, "_reset"}, -1, 11'b0);
    endtask

    task automatic run_table(input string name);
        int   idx;
        int   last;
        exp_t e;
        idx  = 0;
        last = tbl[tbl.size()-1].edge_i;
        sb.delete();
        for (int c = 0; c <= last; c++) begin
            rst = 1'b0;
            req = '0;
            if (idx < tbl.size() && tbl[idx].edge_i == c) begin
                rst = tbl[idx].rst;
                req = tbl[idx].req;
                e.edge_i = c;
                e.v = {tbl[idx].floor, tbl[idx].dir, tbl[idx].moving,
                       tbl[idx].door, tbl[idx].pending};
                sb.push_back(e);
                idx++;
            end
            @(posedge clk);
            #1;
            if (sb.size() > 0 && sb[0].edge_i == c) begin
                e = sb.pop_front();
                check_snap(name, c, e.v);
            end
        end
        rst = 1'b0;
        req = '0;
        tbl.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req = '0;

        // single call to floor 3 from floor 0
        do_reset("up3");
        row(0,  0, 5'b01000, 0, 0, 0, 0, 5'b01000);
        row(1,  0, 5'b00000, 0, 0, 1, 0, 5'b01000);
        row(4,  0, 5'b00000, 0, 0, 1, 0, 5'b01000);
        row(5,  0, 5'b00000, 1, 0, 1, 0, 5'b01000);
        row(9,  0, 5'b00000, 2, 0, 1, 0, 5'b01000);
        row(12, 0, 5'b00000, 2, 0, 1, 0, 5'b01000);
        row(13, 0, 5'b00000, 3, 0, 0, 1, 5'b00000);
        row(15, 0, 5'b00000, 3, 0, 0, 1, 5'b00000);
        row(16, 0, 5'b00000, 3, 0, 0, 0, 5'b00000);
        run_table("up3");

        // call at the current floor opens the door without moving
        do_reset("here");
        row(0, 0, 5'b00001, 0, 0, 0, 0, 5'b00001);
        row(1, 0, 5'b00000, 0, 0, 0, 1, 5'b00000);
        row(2, 0, 5'b00000, 0, 0, 0, 1, 5'b00000);
        row(3, 0, 5'b00000, 0, 0, 0, 1, 5'b00000);
        row(4, 0, 5'b00000, 0, 0, 0, 0, 5'b00000);
        run_table("here");

        // same-floor call during dwell restarts the door timer
        do_reset("restart");
        row(0,  0, 5'b01000, 0, 0, 0, 0, 5'b01000);
        row(13, 0, 5'b00000, 3, 0, 0, 1, 5'b00000);
        row(15, 0, 5'b01000, 3, 0, 0, 1, 5'b00000);
        row(16, 0, 5'b00000, 3, 0, 0, 1, 5'b00000);
        row(17, 0, 5'b00000, 3, 0, 0, 1, 5'b00000);
        row(18, 0, 5'b00000, 3, 0, 0, 0, 5'b00000);
        run_table("restart");

        // four simultaneous calls served bottom to top
        do_reset("sweep");
        row(0,  0, 5'b11110, 0, 0, 0, 0, 5'b11110);
        row(1,  0, 5'b00000, 0, 0, 1, 0, 5'b11110);
        row(5,  0, 5'b00000, 1, 0, 0, 1, 5'b11100);
        row(7,  0, 5'b00000, 1, 0, 0, 1, 5'b11100);
        row(8,  0, 5'b00000, 1, 0, 1, 0, 5'b11100);
        row(12, 0, 5'b00000, 2, 0, 0, 1, 5'b11000);
        row(15, 0, 5'b00000, 2, 0, 1, 0, 5'b11000);
        row(19, 0, 5'b00000, 3, 0, 0, 1, 5'b10000);
        row(22, 0, 5'b00000, 3, 0, 1, 0, 5'b10000);
        row(26, 0, 5'b00000, 4, 0, 0, 1, 5'b00000);
        row(28, 0, 5'b00000, 4, 0, 0, 1, 5'b00000);
        row(29, 0, 5'b00000, 4, 0, 0, 0, 5'b00000);
        run_table("sweep");

        // heading to 4, calls at 1 and 3 arrive: stop 3, 4, reverse, stop 1
        do_reset("scan");
        row(0,  0, 5'b10000, 0, 0, 0, 0, 5'b10000);
        row(9,  0, 5'b00000, 2, 0, 1, 0, 5'b10000);
        row(10, 0, 5'b01010, 2, 0, 1, 0, 5'b11010);
        row(13, 0, 5'b00000, 3, 0, 0, 1, 5'b10010);
        row(16, 0, 5'b00000, 3, 0, 1, 0, 5'b10010);
        row(20, 0, 5'b00000, 4, 0, 0, 1, 5'b00010);
        row(23, 0, 5'b00000, 4, 1, 1, 0, 5'b00010);
        row(27, 0, 5'b00000, 3, 1, 1, 0, 5'b00010);
        row(35, 0, 5'b00000, 1, 1, 0, 1, 5'b00000);
        row(38, 0, 5'b00000, 1, 1, 0, 0, 5'b00000);
        run_table("scan");

        // reset mid-travel (floor 2, travel count 2)
        do_reset("midrst");
        row(0,  0, 5'b10000, 0, 0, 0, 0, 5'b10000);
        row(11, 0, 5'b00000, 2, 0, 1, 0, 5'b10000);
        row(12, 1, 5'b00000, 0, 0, 0, 0, 5'b00000);
        row(13, 0, 5'b00000, 0, 0, 0, 0, 5'b00000);
        run_table("midrst");

        // hand-written: measure door-open and door-close edges for a call to floor 2
        do_reset("timing");
        req        = 5'b00100;
        overlap    = 1'b0;
        open_edge  = -1;
        close_edge = -1;
        n_edges    = 0;
        while (open_edge < 0 && n_edges < 40) begin
            @(posedge clk);
            #1;
            req = '0;
            if (moving && door_open) overlap = 1'b1;
            if (door_open) open_edge = n_edges;
            n_edges++;
        end
        check_int("timing_open_edge", open_edge, 9);
        check_int("timing_open_floor", int'(floor), 2);
        while (close_edge < 0 && n_edges < 60) begin
            @(posedge clk);
            #1;
            if (moving && door_open) overlap = 1'b1;
            if (!door_open) close_edge = n_edges;
            n_edges++;
        end
        check_int("timing_close_edge", close_edge, 12);
        check_int("timing_overlap", int'(overlap), 0);
        check_int("timing_final_dir", int'(dir), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/elevator_call_scheduler.md
# elevator_call_scheduler

Request-latching scheduler for the 5-floor elevator car: captures momentary call-button pulses into a pending-call register, chooses the next target with a SCAN (keep-direction) policy, and sequences the car through travel and door-dwell phases using cycle counters. It is the sequencing layer above the floor/direction FSMs. It drives the car position, direction, motion, and door status presented to the rest of the design.

## Interface
- `NFLOORS`, 5: number of floors, 2..8.
- `TRAVEL_CYC`, 4: clock cycles to travel one floor, >=1.
- `DOOR_CYC`, 3: clock cycles the door stays open, >=1.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NFLOORS  call buttons, one bit per floor, may pulse for one cycle or be held.
- `floor`  out  3  current floor, 0..NFLOORS-1.
- `dir`  out  1  0 = UP, 1 = DOWN.
- `moving`  out  1  high while in MOVE.
- `door_open`  out  1  high while in DOOR.
- `pending`  out  NFLOORS  latched, unserviced calls.

## Operation
- States: IDLE, MOVE, DOOR.
- Reset, applied on the `clk` edge with `rst`=1, sets: state=IDLE, floor=0, dir=UP, moving=0, door_open=0, pending=0, and both counters=0. Reset overrides everything, including mid-MOVE and mid-DOOR.
- Latching: `pending <= (pending | req) & ~clr`.
  - `clr` has only the bit for the floor being entered into DOOR.
  - A `req` bit for the current floor while in DOOR is not latched and restarts the dwell count.
- Terms used in the decision rule:
  - "ahead" = any pending bit strictly beyond `floor` in `dir`.
  - "behind" = any pending bit strictly on the opposite side.
- Decision rule, applied in IDLE and at the end of DOOR, using registered `pending`:
  - pending[floor] set -> DOOR, and clear that bit.
  - Else ahead -> MOVE, keep `dir`.
  - Else behind -> MOVE, invert `dir`.
  - Else -> IDLE, keep `dir`.
- MOVE:
  - The travel counter counts TRAVEL_CYC cycles.
  - On its last cycle: floor <= floor ±1 per `dir`, and the counter resets.
  - If pending[new floor] is set -> DOOR on the same edge, and clear that bit. Otherwise stay in MOVE.
  - Calls are only cleared on service, so a MOVE that has no stop always still has a request ahead.
- DOOR: the dwell counter counts DOOR_CYC cycles, then the decision rule is applied.
- Boundaries:
  - `floor` never leaves 0..NFLOORS-1.
  - At floor 0, "behind" for DOWN is empty. At the top floor, "ahead" for UP is empty.
  - `dir` changes only through the decision rule.
- Simultaneous `req` bits are all latched. Service order follows SCAN only, not arrival order.

## Timing
- All outputs are registered.
- A `req` sampled at edge E0 is visible in `pending` after E0.
- From IDLE, the state changes at E1.
- Floor step: entering MOVE at edge Em -> `floor` updates at Em+TRAVEL_CYC, Em+2·TRAVEL_CYC, …
- `door_open` is high for exactly DOOR_CYC cycles after the edge that enters DOOR, unless a same-floor `req` restarts it.
- `moving` and `door_open` are never high together.

## Structure
- Shared package `elevator_pkg` contains:
  - `state_t` {IDLE, MOVE, DOOR}
  - `dir_t` {UP, DOWN}
  - `FLOOR_W` = 3
  - the default timing constants
- Sub-module `elevator_call_latch` holds the pending register with set/clear/suppress. The ahead/behind masks stay in the top level.

## Test plan
All scenarios use NFLOORS=5, TRAVEL_CYC=4, DOOR_CYC=3, from reset, with E0 the first edge after `rst` deasserts.
- `req`=5'b01000 at E0 -> MOVE at E1; floor=1@E5, 2@E9, 3@E13; DOOR and pending=0 at E13; door_open high E13..E15; IDLE at E16, dir=UP.
- `req`=5'b00001 at E0 while at floor 0 -> DOOR at E1, floor stays 0, moving never high.
- While at floor 3 in DOOR, pulse `req`[3] on the 2nd dwell cycle -> pending[3] stays 0, door_open extended to 3 cycles after the pulse.
- `req`=5'b11110 at E0 -> stops at floors 1, 2, 3, 4 in order, each with a 3-cycle dwell, then IDLE with dir=UP.
- Car at floor 2 moving UP toward 4, then `req`[1] and `req`[3] -> stops at 3, then 4, reverses (dir=DOWN), then stops at 1.
- Assert `rst` for one edge mid-MOVE (floor=2, counter=2) -> after that edge floor=0, dir=UP, moving=0, door_open=0, pending=0, state IDLE.
